// File: rtl/everloop_wr_arbiter.sv
// -----------------------------------------------------------------------------
// everloop_wr_arbiter
//
// Arbitrates writes into the everloop LED RAM write port (port A) between the
// host Wishbone path (requester 0) and the animation engine (requester 1).
// Each granted request carries one 32-bit LED word, which is serialised into
// four byte writes, byte0 first, at byte addresses {idx, 2'b00} .. {idx, 2'b11}.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-low reset
//   hold            while high in IDLE, no new grant starts
//   req0/idx0/dat0  requester 0 request level, LED word index, LED word
//   ack0            one-cycle completion pulse to requester 0
//   req1/idx1/dat1  requester 1 request level, LED word index, LED word
//   ack1            one-cycle completion pulse to requester 1
//   ram_en/ram_we   RAM port A enable / write enable (high only while writing)
//   ram_adr         RAM byte address {idx, byte}
//   ram_dat         RAM write data byte
//   busy            high whenever the FSM is not IDLE
//   gnt_id          requester currently or last served
//   wr_count        completed word writes, wraps modulo 2^16
//   dbg_state       current FSM state (IDLE=0, WR=1, ACK=2)
//
// Handshake: reqN is a level. A requester raises reqN with idxN/datN valid and
// holds all three stable until ackN. The word is latched on the grant edge,
// so dropping reqN afterwards does not cancel the burst; ackN still pulses for
// exactly one cycle. If reqN is still high in the IDLE cycle after ackN, that
// is a new request.
// -----------------------------------------------------------------------------
module everloop_wr_arbiter #(
  parameter int IDX_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  logic                 req0,
  input  logic [IDX_WIDTH-1:0] idx0,
  input  logic [31:0]          dat0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [IDX_WIDTH-1:0] idx1,
  input  logic [31:0]          dat1,
  output logic                 ack1,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [IDX_WIDTH+1:0] ram_adr,
  output logic [7:0]           ram_dat,
  output logic                 busy,
  output logic                 gnt_id,
  output logic [15:0]          wr_count,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]          sh_q, sh_d;
  logic [1:0]           bc_q, bc_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 win;
  logic                 in_wr;
  logic                 in_ack;

  // Round-robin: a lone requester wins; on a tie the one not served last wins.
  // gnt_q resets to 1 so requester 0 takes the first tie.
  assign win = (req0 & req1) ? ~gnt_q : req1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    bc_d    = bc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!hold && (req0 || req1)) begin
          state_d = ST_WR;
          gnt_d   = win;
          idx_d   = win ? idx1 : idx0;
          sh_d    = win ? dat1 : dat0;
          bc_d    = 2'd0;
        end
      end
      ST_WR: begin
        // Low byte is always the one on the bus; shift the next one down.
        sh_d = {8'h00, sh_q[31:8]};
        bc_d = bc_q + 2'd1;
        if (bc_q == 2'd3) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b1;
      idx_q   <= '0;
      sh_q    <= 32'h0;
      bc_q    <= 2'd0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      bc_q    <= bc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset drops them
  // in the same cycle, even mid-burst.
  assign in_wr     = (state_q == ST_WR);
  assign in_ack    = (state_q == ST_ACK);
  assign ram_en    = in_wr;
  assign ram_we    = in_wr;
  assign ram_adr   = in_wr ? {idx_q, bc_q} : '0;
  assign ram_dat   = in_wr ? sh_q[7:0] : 8'h00;
  assign ack0      = in_ack & ~gnt_q;
  assign ack1      = in_ack & gnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign gnt_id    = gnt_q;
  assign wr_count  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_everloop_wr_arbiter.sv
module tb_everloop_wr_arbiter;

  localparam int IW = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          hold;
  logic          req0, req1;
  logic [IW-1:0] idx0, idx1;
  logic [31:0]   dat0, dat1;
  logic          ack0, ack1;
  logic          ram_en, ram_we;
  logic [IW+1:0] ram_adr;
  logic [7:0]    ram_dat;
  logic          busy;
  logic          gnt_id;
  logic [15:0]   wr_count;
  logic [1:0]    dbg_state;

  everloop_wr_arbiter #(.IDX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req0(req0), .idx0(idx0), .dat0(dat0), .ack0(ack0),
    .req1(req1), .idx1(idx1), .dat1(dat1), .ack1(ack1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr), .ram_dat(ram_dat),
    .busy(busy), .gnt_id(gnt_id), .wr_count(wr_count), .dbg_state(dbg_state)
  );

  // Observed output bundle: {en, we, adr, dat, ack0, ack1, busy}
  wire [23:0] obs = {ram_en, ram_we, ram_adr, ram_dat, ack0, ack1, busy};

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int          m_last;   // last served requester
  logic [15:0] m_count;  // completed words

  function automatic int model_winner(input logic r0, input logic r1, input int last);
    if (r0 && r1) return (last == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  // Expected output bundle for cycle c of a word (c=1..4 writes, c=5 ack,
  // c=0 or c=6 idle with nothing in flight).
  function automatic logic [23:0] exp_vec(input int id, input logic [IW-1:0] idx,
                                          input logic [31:0] d, input int c);
    logic          w;
    logic [IW+1:0] a;
    logic [7:0]    b;
    logic [1:0]    bsel;
    w = (c >= 1 && c <= 4);
    a = '0;
    b = 8'h00;
    if (w) begin
      bsel = 2'(c - 1);
      a = {idx, bsel};
      b = 8'(d >> (8 * (c - 1)));
    end
    return {w, w, a, b, (c == 5 && id == 0), (c == 5 && id == 1), (c >= 1 && c <= 5)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; hold = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    idx0 = '0; idx1 = '0; dat0 = '0; dat1 = '0;
    m_last = 1; m_count = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 24'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", obs, 24'h0);
    end
    checks++;
    if (gnt_id !== 1'b1 || wr_count !== 16'h0) begin
      errors++; $display("FAIL reset_gnt_count: got gnt=%b cnt=%h want gnt=1 cnt=0000", gnt_id, wr_count);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 24'h0) begin
      errors++; $display("FAIL reset_idle: got %h want %h", obs, 24'h0);
    end
  endtask

  task automatic test_single();
    logic [23:0] e;
    req0 = 1'b1; idx0 = 9'h005; dat0 = 32'hDDCCBBAA;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      e = exp_vec(0, idx0, dat0, c);
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL single c%0d: got %h want %h", c, obs, e);
      end
      if (c == 5) req0 = 1'b0;
    end
    m_last = 0; m_count = m_count + 16'd1;
    checks++;
    if (wr_count !== m_count || gnt_id !== 1'b0) begin
      errors++; $display("FAIL single_count: got cnt=%h gnt=%b want cnt=%h gnt=0", wr_count, gnt_id, m_count);
    end
  endtask

  task automatic test_round_robin();
    logic [23:0] e;
    int win;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_last = 1; m_count = 16'h0;
    req0 = 1'b1; req1 = 1'b1;
    idx0 = IW'($urandom); idx1 = IW'($urandom);
    dat0 = $urandom; dat1 = $urandom;
    for (int w = 0; w < 4; w++) begin
      win = model_winner(req0, req1, m_last);
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        e = exp_vec(win, win ? idx1 : idx0, win ? dat1 : dat0, c);
        checks++;
        if (obs !== e) begin
          errors++; $display("FAIL rr w%0d c%0d: got %h want %h", w, c, obs, e);
        end
        if (c == 5 && w == 3) begin req0 = 1'b0; req1 = 1'b0; end
      end
      m_last = win; m_count = m_count + 16'd1;
      checks++;
      if (gnt_id !== 1'(win) || wr_count !== m_count) begin
        errors++; $display("FAIL rr_gnt w%0d: got gnt=%b cnt=%h want gnt=%0d cnt=%h", w, gnt_id, wr_count, win, m_count);
      end
    end
    checks++;
    if (wr_count !== 16'd4) begin
      errors++; $display("FAIL rr_total: got %h want 0004", wr_count);
    end
  endtask

  task automatic test_hold();
    logic [23:0] e;
    int bad;
    hold = 1'b1; req1 = 1'b1;
    idx1 = IW'($urandom); dat1 = $urandom;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_we !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_blocks: got %0d active cycles want 0", bad);
    end
    hold = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      e = exp_vec(1, idx1, dat1, c);
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL hold_burst c%0d: got %h want %h", c, obs, e);
      end
      if (c == 2) hold = 1'b1;   // raised mid-burst, must not disturb it
      if (c == 5) req1 = 1'b0;
    end
    m_last = 1; m_count = m_count + 16'd1;
    checks++;
    if (wr_count !== m_count) begin
      errors++; $display("FAIL hold_count: got %h want %h", wr_count, m_count);
    end
    hold = 1'b0;
  endtask

  task automatic test_withdraw();
    logic [23:0] e;
    req1 = 1'b1; idx1 = IW'($urandom); dat1 = $urandom;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      e = exp_vec(1, idx1, dat1, c);
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL withdraw c%0d: got %h want %h", c, obs, e);
      end
      if (c == 1) req1 = 1'b0;
    end
    m_last = 1; m_count = m_count + 16'd1;
    checks++;
    if (wr_count !== m_count) begin
      errors++; $display("FAIL withdraw_count: got %h want %h", wr_count, m_count);
    end
  endtask

  task automatic test_random();
    logic [23:0] e;
    int win, gap, pat;
    for (int w = 0; w < 12; w++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if (obs !== 24'h0) begin
          errors++; $display("FAIL rand_gap w%0d: got %h want %h", w, obs, 24'h0);
        end
      end
      pat = $urandom_range(1, 3);
      req0 = pat[0]; req1 = pat[1];
      idx0 = IW'($urandom); idx1 = IW'($urandom);
      dat0 = $urandom; dat1 = $urandom;
      win = model_winner(req0, req1, m_last);
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        e = exp_vec(win, win ? idx1 : idx0, win ? dat1 : dat0, c);
        checks++;
        if (obs !== e) begin
          errors++; $display("FAIL rand w%0d c%0d: got %h want %h", w, c, obs, e);
        end
        if (c == 5) begin req0 = 1'b0; req1 = 1'b0; end
      end
      m_last = win; m_count = m_count + 16'd1;
      checks++;
      if (gnt_id !== 1'(win) || wr_count !== m_count) begin
        errors++; $display("FAIL rand_gnt w%0d: got gnt=%b cnt=%h want gnt=%0d cnt=%h", w, gnt_id, wr_count, win, m_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] e;
    int bad;
    req0 = 1'b1; idx0 = IW'($urandom); dat0 = $urandom;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      e = exp_vec(0, idx0, dat0, c);
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL rstmid_pre c%0d: got %h want %h", c, obs, e);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({ram_en, ram_we, busy} !== 3'b000 || gnt_id !== 1'b1 || wr_count !== 16'h0) begin
      errors++; $display("FAIL rstmid_async: got en/we/busy=%b gnt=%b cnt=%h want 000 1 0000",
                         {ram_en, ram_we, busy}, gnt_id, wr_count);
    end
    req0 = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rstmid_noack: got %0d bad cycles want 0", bad);
    end
    reset = 1'b1;
    m_last = 1; m_count = 16'h0;
    @(negedge clk);
    req0 = 1'b1; idx0 = IW'($urandom); dat0 = $urandom;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      e = exp_vec(0, idx0, dat0, c);
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL rstmid_post c%0d: got %h want %h", c, obs, e);
      end
      if (c == 5) req0 = 1'b0;
    end
    m_last = 0; m_count = 16'd1;
    checks++;
    if (wr_count !== m_count) begin
      errors++; $display("FAIL rstmid_count: got %h want %h", wr_count, m_count);
    end
  endtask

  task automatic test_wrap();
    logic [23:0] e;
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_count = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (wr_count !== m_count) begin
      errors++; $display("FAIL wrap_preload: got %h want %h", wr_count, m_count);
    end
    req1 = 1'b1; idx1 = IW'($urandom); dat1 = $urandom;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      e = exp_vec(1, idx1, dat1, c);
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL wrap c%0d: got %h want %h", c, obs, e);
      end
      if (c == 5) begin
        checks++;
        if (wr_count !== 16'hFFFF) begin
          errors++; $display("FAIL wrap_ack: got %h want ffff", wr_count);
        end
        req1 = 1'b0;
      end
    end
    m_count = m_count + 16'd1;
    checks++;
    if (wr_count !== m_count) begin
      errors++; $display("FAIL wrap_zero: got %h want %h", wr_count, m_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_withdraw();
    test_random();
    test_reset_mid();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/everloop_wr_arbiter.md
# everloop_wr_arbiter

Arbitrates and sequences writes into the everloop LED RAM write port (port A) from two independent requesters: the host Wishbone slave path and the on-chip pattern/animation engine. Each request carries one 32-bit LED word. The block serialises it into four byte writes on the 8-bit RAM port. The everloop driver keeps sole ownership of the read port (port B) and is not involved.

## Interface
- IDX_WIDTH, 9, LED word index width; the RAM byte address is IDX_WIDTH+2 bits wide (default 11).
- clk  in  1  system clock; everything is clocked on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- hold  in  1  while high, no new grant starts; a burst already in flight completes.
- req0  in  1  requester 0 (host path) write request, level.
- idx0  in  IDX_WIDTH  requester 0 LED word index.
- dat0  in  32  requester 0 LED word, {byte3,byte2,byte1,byte0}.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, idx1, dat1, ack1: same meanings for requester 1 (animation engine).
- ram_en  out  1  RAM port A enable.
- ram_we  out  1  RAM port A write enable.
- ram_adr  out  IDX_WIDTH+2  RAM byte address.
- ram_dat  out  8  RAM write data.
- busy  out  1  high whenever the state is not IDLE.
- gnt_id  out  1  requester currently or last served.
- wr_count  out  16  number of completed word writes; wraps modulo 2^16.

## Operation
- FSM states are IDLE, WR, ACK.
- IDLE to WR when hold=0 and (req0|req1). On that edge:
  - latch winner id into gnt_id;
  - latch idx into idx_q and dat into shift register sh;
  - clear byte counter bc (2 bits).
- WR lasts exactly 4 cycles, bc = 0..3.
  - ram_en = ram_we = 1.
  - ram_adr = {idx_q, bc}; ram_dat = sh[7:0].
  - Each edge: sh <= sh >> 8, bc <= bc + 1.
  - After bc=3, go to ACK.
- ACK lasts 1 cycle: ack[gnt_id] = 1, wr_count increments. Then go to IDLE.
- Arbitration is round-robin using gnt_id as the last-served pointer.
  - Only one requester asserting: that requester wins.
  - Both asserting: the requester that is not gnt_id wins.
- Byte order: dat[7:0] goes to {idx,2'b00} and dat[31:24] goes to {idx,2'b11}.
- Requester contract: hold req, idx and dat stable until its ack. Deasserting req at ack or later ends the request; if req is still high in the IDLE cycle after ack, that counts as a new request.
- If req drops after latch (mid-burst), the burst still completes and ack still pulses.
- hold is sampled only in IDLE. Asserting hold during WR or ACK has no effect on the current burst.
- ram_* outputs are 0 outside WR. ack0/ack1 are 0 outside ACK.

## Timing
- Reset values: state=IDLE, all outputs 0, gnt_id=1 (so req0 wins the first tie), wr_count=0, sh=0.
- Reset assertion forces these values immediately, asynchronously, including mid-burst. A partially written word is not rolled back; its ack never fires.
- Latency, with cycle 0 = IDLE cycle in which the request is sampled:
  - RAM writes in cycles 1–4;
  - ack in cycle 5;
  - IDLE in cycle 6, where the next request is sampled.
- Throughput is one word per 6 cycles. Two requesters continuously asserting alternate every 6 cycles.
- wr_count updates on the edge ending ACK and is visible from cycle 6.
- busy is high in cycles 1–5.

## Test plan
- Single request: after reset, req0=1, idx0=9'h005, dat0=32'hDDCCBBAA. Required: cycles 1–4 write adr 0x014/AA, 0x015/BB, 0x016/CC, 0x017/DD; ack0 in cycle 5; wr_count=1.
- Tie and round-robin: req0 and req1 held high for 4 words. Required grant order 0,1,0,1; acks 6 cycles apart; gnt_id toggles; wr_count=4.
- hold: hold=1 with req1 high for 10 cycles, then hold=0. Required: ram_we stays 0 and busy stays 0 while hold is high; the burst starts 1 cycle after hold falls. Second case: hold raised in WR cycle 2 leaves that burst intact.
- Request withdrawn: req1 deasserted in WR cycle 1. Required: all 4 bytes are still written and ack1 pulses in cycle 5.
- Reset mid-burst: reset low during WR cycle 2. Required: ram_en, ram_we and busy fall to 0 in the same cycle; no ack; wr_count=0; gnt_id=1. After release, a new req0 is served normally.
- Counter wrap: force 65536 completed writes (or preload via a bench shortcut at 16'hFFFF). Required: wr_count goes 16'hFFFF to 16'h0000.
